// File: rtl/dccm_ctrl_pkg.sv
// Shared types and defaults for the DCCM responder.
// Optional zero-fill after reset is enabled with the DCCM_INIT_EN macro.
package dccm_ctrl_pkg;

   localparam int DCCM_XLEN   = 32;
   localparam int DCCM_DEPTH  = 1024;
   localparam int DCCM_RD_LAT = 2;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      INIT  = 2'd1,
      READY = 2'd2
   } dccm_state_t;

   // State taken on the first cycle after reset is released.
`ifdef DCCM_INIT_EN
   localparam dccm_state_t START_STATE = INIT;
`else
   localparam dccm_state_t START_STATE = READY;
`endif

   function automatic logic addr_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/dccm_ram.sv
// DEPTH x XLEN 1R1W array: synchronous write, registered read, no reset.
// A same-cycle read of the written word returns the old contents.
module dccm_ram #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [XLEN-1:0]          wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [XLEN-1:0]          rdata
);

   logic [XLEN-1:0] mem_reg [DEPTH];
   logic [XLEN-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
      if (re) begin
         rdata_reg <= mem_reg[raddr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/dccm_ctrl.sv
// DCCM responder: address checks, write forwarding, read pipeline and init FSM.
// Defining DCCM_INIT_EN adds the post-reset zero-fill of the whole array.
module dccm_ctrl
   import dccm_ctrl_pkg::*;
#(
   parameter int XLEN   = DCCM_XLEN,
   parameter int DEPTH  = DCCM_DEPTH,
   parameter int RD_LAT = DCCM_RD_LAT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] dccm_raddr,
   input  logic            dccm_rvalid_in,
   output logic [XLEN-1:0] dccm_rdata,
   output logic            dccm_rvalid_out,
   input  logic [XLEN-1:0] dccm_waddr,
   input  logic            dccm_wen,
   input  logic [XLEN-1:0] dccm_wdata,
   output logic            dccm_busy,
   output logic            dccm_err
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]   ridx;
   logic [AW-1:0]   widx;
   logic            rd_good;
   logic            wr_good;
   logic            rd_ok;
   logic            wr_ok;
   logic            wr_err;
   logic            fwd;

   dccm_state_t     state_reg;
   dccm_state_t     state;
   dccm_state_t     state_next;
   logic            init_we;

   logic            ram_we;
   logic [AW-1:0]   ram_widx;
   logic [XLEN-1:0] ram_wdata;
   logic [XLEN-1:0] ram_rdata;

   logic            v1_reg;
   logic            ok1_reg;
   logic            fwd1_reg;
   logic [XLEN-1:0] fwd_data1_reg;
   logic            wr_err_reg;
   logic [XLEN-1:0] data1;
   logic            rd_err1;
   logic            rd_err_out;

   // DEPTH is a power of two, so in-range means all bits above the index are 0.
   assign ridx    = dccm_raddr[AW+1:2];
   assign widx    = dccm_waddr[AW+1:2];
   assign rd_good = (dccm_raddr[XLEN-1:AW+2] == '0) && addr_aligned(dccm_raddr[1:0]);
   assign wr_good = (dccm_waddr[XLEN-1:AW+2] == '0) && addr_aligned(dccm_waddr[1:0]);
   assign rd_ok   = dccm_rvalid_in && rd_good && !dccm_busy;
   assign wr_ok   = dccm_wen && wr_good && !dccm_busy;
   assign wr_err  = dccm_wen && !wr_ok;
   assign fwd     = rd_ok && wr_ok && (ridx == widx);

`ifdef DCCM_INIT_EN
   logic [AW-1:0] cnt_reg;
   logic [AW-1:0] cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RESET;
      end else begin
         state_reg <= state_next;
      end
   end

   // The visible state leaves RESET in the first cycle with rst low.
   always_comb begin
      state      = state_reg;
      state_next = state_reg;
      init_we    = 1'b0;
`ifdef DCCM_INIT_EN
      cnt_next   = cnt_reg;
`endif
      if (rst) begin
         state = RESET;
      end else if (state_reg == RESET) begin
         state = START_STATE;
      end
      state_next = state;
      case (state)
         INIT: begin
`ifdef DCCM_INIT_EN
            init_we  = 1'b1;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == AW'(DEPTH - 1)) begin
               state_next = READY;
            end
`endif
         end
         default: ;
      endcase
   end

   assign dccm_busy = (state != READY);

`ifdef DCCM_INIT_EN
   assign ram_we    = init_we || wr_ok;
   assign ram_widx  = init_we ? cnt_reg : widx;
   assign ram_wdata = init_we ? '0 : dccm_wdata;
`else
   assign ram_we    = init_we || wr_ok;
   assign ram_widx  = widx;
   assign ram_wdata = dccm_wdata;
`endif

   dccm_ram #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_widx),
      .wdata (ram_wdata),
      .re    (rd_ok),
      .raddr (ridx),
      .rdata (ram_rdata)
   );

   // First stage runs alongside the RAM's registered read.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg     <= 1'b0;
         ok1_reg    <= 1'b0;
         fwd1_reg   <= 1'b0;
         wr_err_reg <= 1'b0;
      end else begin
         v1_reg     <= dccm_rvalid_in;
         ok1_reg    <= rd_ok;
         fwd1_reg   <= fwd;
         wr_err_reg <= wr_err;
      end
      if (fwd) begin
         fwd_data1_reg <= dccm_wdata;
      end
   end

   assign data1   = !ok1_reg ? '0 : (fwd1_reg ? fwd_data1_reg : ram_rdata);
   assign rd_err1 = v1_reg && !ok1_reg;

   generate
      if (RD_LAT == 1) begin : g_lat1
         logic [XLEN-1:0] hold_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               hold_reg <= '0;
            end else if (v1_reg) begin
               hold_reg <= data1;
            end
         end

         assign dccm_rdata      = v1_reg ? data1 : hold_reg;
         assign dccm_rvalid_out = v1_reg;
         assign rd_err_out      = rd_err1;
      end else begin : g_lat2
         logic [XLEN-1:0] rdata_reg;
         logic            rvalid_reg;
         logic            rd_err_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_reg  <= '0;
               rvalid_reg <= 1'b0;
               rd_err_reg <= 1'b0;
            end else begin
               rvalid_reg <= v1_reg;
               rd_err_reg <= rd_err1;
               if (v1_reg) begin
                  rdata_reg <= data1;
               end
            end
         end

         assign dccm_rdata      = rdata_reg;
         assign dccm_rvalid_out = rvalid_reg;
         assign rd_err_out      = rd_err_reg;
      end
   endgenerate

   // Write errors report one cycle after issue, read errors with their data.
   assign dccm_err = rd_err_out || wr_err_reg;

endmodule

// File: tb/tb_dccm_ctrl.sv
// Self-checking bench for dccm_ctrl against a transaction-level memory model.
// Honours DCCM_INIT_EN the same way the design does.
module tb_dccm_ctrl;

   localparam int XLEN   = 32;
   localparam int DEPTH  = 1024;
   localparam int RD_LAT = 2;
`ifdef DCCM_INIT_EN
   localparam bit INIT_ON = 1'b1;
`else
   localparam bit INIT_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] dccm_raddr;
   logic            dccm_rvalid_in;
   logic [XLEN-1:0] dccm_rdata;
   logic            dccm_rvalid_out;
   logic [XLEN-1:0] dccm_waddr;
   logic            dccm_wen;
   logic [XLEN-1:0] dccm_wdata;
   logic            dccm_busy;
   logic            dccm_err;

   dccm_ctrl #(
      .XLEN   (XLEN),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .dccm_raddr      (dccm_raddr),
      .dccm_rvalid_in  (dccm_rvalid_in),
      .dccm_rdata      (dccm_rdata),
      .dccm_rvalid_out (dccm_rvalid_out),
      .dccm_waddr      (dccm_waddr),
      .dccm_wen        (dccm_wen),
      .dccm_wdata      (dccm_wdata),
      .dccm_busy       (dccm_busy),
      .dccm_err        (dccm_err)
   );

   always #5 clk = ~clk;

   // Reference model: word array, pending responses keyed by due edge.
   typedef struct {
      int          due;
      logic [31:0] data;
      bit          known;
      bit          err;
   } resp_t;

   logic [31:0] mem_m   [DEPTH];
   bit          known_m [DEPTH];
   resp_t       pend [$];
   int          edge_no    = 0;
   int          busy_left  = 0;
   bit          wr_err_now = 1'b0;
   logic [31:0] last_data  = '0;
   bit          last_known = 1'b0;
   bit          exp_valid;
   bit          exp_err;
   bit          exp_known;
   logic [31:0] exp_data;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic bit addr_ok(input logic [31:0] a);
      return (a < 32'(DEPTH * 4)) && (a[1:0] == 2'b00);
   endfunction

   task automatic idle();
      dccm_rvalid_in = 1'b0;
      dccm_raddr     = '0;
      dccm_wen       = 1'b0;
      dccm_waddr     = '0;
      dccm_wdata     = '0;
   endtask

   // Advance one clock, applying the current inputs to the model, and
   // compute what the DUT should show in the new cycle.
   task automatic cycle();
      logic [31:0] ra, wa, wd;
      bit          rv, we, r_rst, busy_now, rgood, wgood;
      resp_t       r;
      ra = dccm_raddr; wa = dccm_waddr; wd = dccm_wdata;
      rv = dccm_rvalid_in; we = dccm_wen; r_rst = rst;
      busy_now = r_rst || (busy_left > 0);
      rgood = rv && addr_ok(ra) && !busy_now;
      wgood = we && addr_ok(wa) && !busy_now;
      @(posedge clk);
      edge_no++;
      if (r_rst) begin
         pend.delete();
         last_data  = '0;
         last_known = 1'b1;
         wr_err_now = 1'b0;
         busy_left  = INIT_ON ? DEPTH : 0;
         if (!INIT_ON) begin
            for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
         end
      end else begin
         if (rv) begin
            r.due = edge_no + RD_LAT - 1;
            if (rgood) begin
               r.err = 1'b0;
               if (wgood && ((wa >> 2) == (ra >> 2))) begin
                  r.data  = wd;
                  r.known = 1'b1;
               end else begin
                  r.data  = mem_m[ra >> 2];
                  r.known = known_m[ra >> 2];
               end
            end else begin
               r.err   = 1'b1;
               r.data  = '0;
               r.known = 1'b1;
            end
            pend.push_back(r);
         end
         if (wgood) begin
            mem_m[wa >> 2]   = wd;
            known_m[wa >> 2] = 1'b1;
            $display("wr   edge=%0d addr=%h data=%h", edge_no, wa, wd);
         end
         wr_err_now = we && !wgood;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem_m[i]   = '0;
                  known_m[i] = 1'b1;
               end
            end
         end
      end
      exp_valid = 1'b0;
      exp_err   = wr_err_now;
      if (pend.size() > 0 && pend[0].due == edge_no) begin
         r = pend.pop_front();
         exp_valid  = 1'b1;
         exp_err    = exp_err | r.err;
         last_data  = r.data;
         last_known = r.known;
      end
      exp_data  = last_data;
      exp_known = last_known;
      #1;
      if (exp_valid) $display("rd   edge=%0d data=%h err=%b", edge_no, dccm_rdata, dccm_err);
   endtask

   task automatic test_reset();
      int n_busy;
      n_busy = 0;
      rst = 1'b1;
      idle();
      repeat (3) cycle();
      n_checks++;
      if (dccm_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", dccm_busy); else n_pass++;
      n_checks++;
      if (dccm_rvalid_out !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", dccm_rvalid_out); else n_pass++;
      n_checks++;
      if (dccm_err !== 1'b0) $display("FAIL reset_err: got %b want 0", dccm_err); else n_pass++;
      n_checks++;
      if (dccm_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", dccm_rdata); else n_pass++;
      rst = 1'b0;
      #1;
      for (int i = 0; i < DEPTH + 4; i++) begin
         n_checks++;
         if (dccm_busy !== 1'(busy_left > 0))
            $display("FAIL init_busy cycle %0d: got %b want %b", i, dccm_busy, busy_left > 0);
         else n_pass++;
         if (dccm_busy) n_busy++;
         dccm_rvalid_in = (i == 5) || (i == DEPTH);
         dccm_raddr     = 32'h10;
         cycle();
         n_checks++;
         if (dccm_rvalid_out !== exp_valid)
            $display("FAIL init_rvalid cycle %0d: got %b want %b", i, dccm_rvalid_out, exp_valid);
         else n_pass++;
         n_checks++;
         if (dccm_err !== exp_err)
            $display("FAIL init_err cycle %0d: got %b want %b", i, dccm_err, exp_err);
         else n_pass++;
         if (exp_valid && exp_known) begin
            n_checks++;
            if (dccm_rdata !== exp_data)
               $display("FAIL init_rdata cycle %0d: got %h want %h", i, dccm_rdata, exp_data);
            else n_pass++;
         end
      end
      idle();
      n_checks++;
      if (n_busy != (INIT_ON ? DEPTH : 0))
         $display("FAIL busy_cycles: got %0d want %0d", n_busy, INIT_ON ? DEPTH : 0);
      else n_pass++;
   endtask

`ifdef DCCM_INIT_EN
   task automatic test_init_zero();
      for (int i = 0; i < 16 + RD_LAT; i++) begin
         idle();
         if (i < 16) begin
            dccm_rvalid_in = 1'b1;
            dccm_raddr     = 32'($urandom_range(0, DEPTH - 1)) << 2;
         end
         cycle();
         if (exp_valid) begin
            n_checks++;
            if (dccm_rdata !== 32'h0 || dccm_err !== 1'b0)
               $display("FAIL init_zero: got data=%h err=%b want data=0 err=0", dccm_rdata, dccm_err);
            else n_pass++;
         end
      end
      idle();
   endtask
`endif

   task automatic test_write_read();
      idle();
      dccm_wen = 1'b1; dccm_waddr = 32'h40; dccm_wdata = 32'hDEADBEEF;
      cycle();
      idle();
      dccm_rvalid_in = 1'b1; dccm_raddr = 32'h40;
      cycle();
      idle();
      cycle();
      n_checks++;
      if (dccm_rvalid_out !== 1'b1 || dccm_rdata !== 32'hDEADBEEF || dccm_err !== 1'b0)
         $display("FAIL write_read: got v=%b d=%h e=%b want v=1 d=deadbeef e=0",
                  dccm_rvalid_out, dccm_rdata, dccm_err);
      else n_pass++;
      cycle();
      n_checks++;
      if (dccm_rvalid_out !== 1'b0 || dccm_rdata !== 32'hDEADBEEF)
         $display("FAIL write_read_hold: got v=%b d=%h want v=0 d=deadbeef", dccm_rvalid_out, dccm_rdata);
      else n_pass++;
   endtask

   task automatic test_forwarding();
      idle();
      dccm_wen = 1'b1; dccm_waddr = 32'h80; dccm_wdata = 32'hAAAA0000;
      cycle();
      dccm_wdata = 32'h12345678;
      dccm_rvalid_in = 1'b1; dccm_raddr = 32'h80;
      cycle();
      idle();
      cycle();
      n_checks++;
      if (dccm_rvalid_out !== 1'b1 || dccm_rdata !== 32'h12345678)
         $display("FAIL forwarding: got v=%b d=%h want v=1 d=12345678", dccm_rvalid_out, dccm_rdata);
      else n_pass++;
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      for (int k = 0; k < 3; k++) begin
         vals[k] = $urandom;
         idle();
         dccm_wen = 1'b1; dccm_waddr = 32'(k * 4); dccm_wdata = vals[k];
         cycle();
      end
      for (int k = 0; k < 5; k++) begin
         idle();
         if (k < 3) begin
            dccm_rvalid_in = 1'b1; dccm_raddr = 32'(k * 4);
         end
         cycle();
         if (k >= 1 && k <= 3) begin
            n_checks++;
            if (dccm_rvalid_out !== 1'b1 || dccm_rdata !== vals[k-1])
               $display("FAIL b2b_%0d: got v=%b d=%h want v=1 d=%h", k - 1, dccm_rvalid_out, dccm_rdata, vals[k-1]);
            else n_pass++;
         end else if (k == 4) begin
            n_checks++;
            if (dccm_rvalid_out !== 1'b0 || dccm_rdata !== vals[2])
               $display("FAIL b2b_hold: got v=%b d=%h want v=0 d=%h", dccm_rvalid_out, dccm_rdata, vals[2]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] bad [2];
      bad[0] = 32'h1000;
      bad[1] = 32'h42;
      for (int k = 0; k < 2; k++) begin
         idle();
         dccm_rvalid_in = 1'b1; dccm_raddr = bad[k];
         cycle();
         idle();
         cycle();
         n_checks++;
         if (dccm_rvalid_out !== 1'b1 || dccm_err !== 1'b1 || dccm_rdata !== 32'h0)
            $display("FAIL rd_err %h: got v=%b e=%b d=%h want v=1 e=1 d=0",
                     bad[k], dccm_rvalid_out, dccm_err, dccm_rdata);
         else n_pass++;
      end
      idle();
      dccm_wen = 1'b1; dccm_waddr = 32'h0; dccm_wdata = 32'h55AA55AA;
      cycle();
      for (int k = 0; k < 2; k++) begin
         idle();
         dccm_wen = 1'b1; dccm_waddr = (k == 0) ? 32'h1000 : 32'h2; dccm_wdata = 32'hFFFFFFFF;
         cycle();
         idle();
         n_checks++;
         if (dccm_err !== 1'b1 || dccm_rvalid_out !== 1'b0)
            $display("FAIL wr_err %0d: got e=%b v=%b want e=1 v=0", k, dccm_err, dccm_rvalid_out);
         else n_pass++;
         cycle();
         n_checks++;
         if (dccm_err !== 1'b0) $display("FAIL wr_err_pulse %0d: got e=%b want 0", k, dccm_err); else n_pass++;
      end
      dccm_rvalid_in = 1'b1; dccm_raddr = 32'h0;
      cycle();
      idle();
      cycle();
      n_checks++;
      if (dccm_rvalid_out !== 1'b1 || dccm_rdata !== 32'h55AA55AA || dccm_err !== 1'b0)
         $display("FAIL wr_err_unchanged: got v=%b d=%h e=%b want v=1 d=55aa55aa e=0",
                  dccm_rvalid_out, dccm_rdata, dccm_err);
      else n_pass++;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] w;
      w = 32'($urandom_range(0, 63)) << 2;
      case ($urandom_range(0, 9))
         0:       return w | 32'($urandom_range(1, 3));
         1:       return $urandom | 32'h1000;
         default: return w;
      endcase
   endfunction

   task automatic test_random();
      for (int w = 0; w < 64; w++) begin
         idle();
         dccm_wen = 1'b1; dccm_waddr = 32'(w * 4); dccm_wdata = $urandom;
         cycle();
      end
      for (int i = 0; i < 300; i++) begin
         idle();
         dccm_rvalid_in = 1'($urandom_range(0, 1));
         dccm_raddr     = rand_addr();
         dccm_wen       = 1'($urandom_range(0, 1));
         dccm_waddr     = ($urandom_range(0, 3) == 0) ? dccm_raddr : rand_addr();
         dccm_wdata     = $urandom;
         cycle();
         n_checks++;
         if (dccm_rvalid_out !== exp_valid)
            $display("FAIL rand_rvalid %0d: got %b want %b", i, dccm_rvalid_out, exp_valid);
         else n_pass++;
         n_checks++;
         if (dccm_err !== exp_err)
            $display("FAIL rand_err %0d: got %b want %b", i, dccm_err, exp_err);
         else n_pass++;
         n_checks++;
         if (dccm_busy !== 1'b0) $display("FAIL rand_busy %0d: got %b want 0", i, dccm_busy); else n_pass++;
         if (exp_known) begin
            n_checks++;
            if (dccm_rdata !== exp_data)
               $display("FAIL rand_rdata %0d: got %h want %h", i, dccm_rdata, exp_data);
            else n_pass++;
         end
      end
      idle();
      repeat (RD_LAT) cycle();
   endtask

   task automatic test_reset_mid();
      idle();
      dccm_wen = 1'b1; dccm_waddr = 32'h20; dccm_wdata = 32'hC0FFEE01;
      cycle();
      idle();
      dccm_rvalid_in = 1'b1; dccm_raddr = 32'h20;
      cycle();
      idle();
      cycle();
      n_checks++;
      if (dccm_rdata !== 32'hC0FFEE01) $display("FAIL mid_pre: got %h want c0ffee01", dccm_rdata); else n_pass++;
      dccm_rvalid_in = 1'b1; dccm_raddr = 32'h20;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      idle();
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (dccm_rvalid_out !== 1'b0 || dccm_err !== 1'b0 || dccm_rdata !== 32'h0)
            $display("FAIL mid_reset %0d: got v=%b e=%b d=%h want v=0 e=0 d=0",
                     i, dccm_rvalid_out, dccm_err, dccm_rdata);
         else n_pass++;
         cycle();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
`ifdef DCCM_INIT_EN
      test_init_zero();
`endif
      test_write_read();
      test_forwarding();
      test_back_to_back();
      test_errors();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
